// File: rtl/sram_burst_reader_pkg.sv
// rtl/sram_burst_reader_pkg.sv - shared widths and FSM encoding for SRAM burst readers
package sram_burst_reader_pkg;
  localparam int DATA_W_DEF = 128;
  localparam int ADDR_W_DEF = 11;
  localparam int LEN_W_DEF  = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } rd_state_t;
endpackage

// File: rtl/rd_fifo2.sv
// rtl/rd_fifo2.sv - 2-entry registered FIFO carrying {last, data}
module rd_fifo2 #(
  parameter int DATA_W = 128
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              PUSH,
  input  logic [DATA_W-1:0] PUSH_DATA,
  input  logic              PUSH_LAST,
  input  logic              POP,
  output logic [1:0]        COUNT,
  output logic              HEAD_VALID,
  output logic [DATA_W-1:0] HEAD_DATA,
  output logic              HEAD_LAST
);
  logic [DATA_W:0] head_q;
  logic [DATA_W:0] tail_q;
  logic [1:0]      count_q;
  logic            pop_ok;
  logic [DATA_W:0] push_word;

  assign pop_ok    = POP && (count_q != 2'd0);
  assign push_word = {PUSH_LAST, PUSH_DATA};

  // Head is always entry 0 so the output is driven straight from a register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      case ({PUSH, pop_ok})
        2'b10: begin
          if (count_q == 2'd0) head_q <= push_word;
          else                 tail_q <= push_word;
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          head_q  <= tail_q;
          count_q <= count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            head_q <= push_word;
          end else begin
            head_q <= tail_q;
            tail_q <= push_word;
          end
        end
        default: ;
      endcase
    end
  end

  assign COUNT      = count_q;
  assign HEAD_VALID = (count_q != 2'd0);
  assign HEAD_DATA  = head_q[DATA_W-1:0];
  assign HEAD_LAST  = head_q[DATA_W] & HEAD_VALID;
endmodule

// File: rtl/sram_burst_reader.sv
// rtl/sram_burst_reader.sv - burst read engine turning SRAM read timing into a valid/ready stream
module sram_burst_reader
  import sram_burst_reader_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [ADDR_W-1:0] BASE_ADDR,
  input  logic [LEN_W-1:0]  LEN,
  output logic              BUSY,
  output logic              DONE,
  output logic              EN_M,
  output logic [ADDR_W-1:0] ADDR,
  input  logic [DATA_W-1:0] SRAM_DOUT,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [DATA_W-1:0] OUT_DATA,
  output logic              OUT_LAST
);
  rd_state_t         state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  remaining_q;
  logic              inflight_q;
  logic              inflight_last_q;
  logic              issue;
  logic              pop;
  logic [1:0]        fifo_count;
  logic [2:0]        occ;

  assign pop = OUT_VALID & OUT_READY;
  // Words held or on their way after this cycle's pop; must stay within the 2-entry FIFO.
  assign occ = 3'(fifo_count) + 3'(inflight_q) - 3'(pop);

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    case (state_q)
      IDLE: begin
        // An empty burst passes through DRAIN so DONE lands two cycles after START.
        if (START) state_d = (LEN != '0) ? ISSUE : DRAIN;
      end
      ISSUE: begin
        if ((remaining_q != '0) && (occ < 3'd2)) begin
          issue = 1'b1;
          if (remaining_q == LEN_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!inflight_q && (occ == 3'd0)) state_d = FIN;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      remaining_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      inflight_q      <= issue;
      inflight_last_q <= issue && (remaining_q == LEN_W'(1));
      if ((state_q == IDLE) && START && (LEN != '0)) begin
        addr_q      <= BASE_ADDR;
        remaining_q <= LEN;
      end else if (issue) begin
        addr_q      <= addr_q + ADDR_W'(1);
        remaining_q <= remaining_q - LEN_W'(1);
      end
    end
  end

  assign EN_M = issue;
  assign ADDR = addr_q;
  assign BUSY = (state_q != IDLE);
  assign DONE = (state_q == FIN);

  rd_fifo2 #(.DATA_W(DATA_W)) u_fifo (
    .CLK        (CLK),
    .RST        (RST),
    .PUSH       (inflight_q),
    .PUSH_DATA  (SRAM_DOUT),
    .PUSH_LAST  (inflight_last_q),
    .POP        (pop),
    .COUNT      (fifo_count),
    .HEAD_VALID (OUT_VALID),
    .HEAD_DATA  (OUT_DATA),
    .HEAD_LAST  (OUT_LAST)
  );
endmodule
